// File: rtl/muldiv_seq_if.sv
// Operation request, result and shared-ALU signals between the execute stage and muldiv_seq.
// The master side issues operations and owns the ALU; the slave side is the sequencer.
interface muldiv_seq_if #(
  parameter int WIDTH = 16
);
  logic             start;
  logic             op;
  logic [WIDTH-1:0] opa;
  logic [WIDTH-1:0] opb;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] result_hi;
  logic [WIDTH-1:0] result_lo;
  logic             div_by_zero;
  logic [31:0]      alu_a;
  logic [31:0]      alu_b;
  logic [1:0]       alu_ctrl;
  logic [31:0]      alu_out;

  modport master (
    output start, op, opa, opb, alu_out,
    input  busy, done, result_hi, result_lo, div_by_zero, alu_a, alu_b, alu_ctrl
  );

  modport slave (
    input  start, op, opa, opb, alu_out,
    output busy, done, result_hi, result_lo, div_by_zero, alu_a, alu_b, alu_ctrl
  );
endinterface

// File: rtl/muldiv_seq.sv
// Multi-cycle unsigned multiply (shift-add) / divide (restoring) sequencer that
// borrows the shared 32-bit ALU for one iteration per clock.
module muldiv_seq #(
  parameter int WIDTH = 16
) (
  input logic         clk,
  input logic         rst,
  muldiv_seq_if.slave bus
);
  localparam int CW = $clog2(WIDTH);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  localparam logic [1:0] ALU_ADD = 2'b00;
  localparam logic [1:0] ALU_SUB = 2'b01;

  state_t           state_q, state_d;
  logic             op_q, op_d;
  logic [WIDTH-1:0] opa_q, opa_d;
  logic [WIDTH-1:0] opb_q, opb_d;
  logic [31:0]      acc_q, acc_d;
  logic [CW-1:0]    count_q, count_d;
  logic [WIDTH-1:0] quot_q, quot_d;
  logic [WIDTH-1:0] res_hi_q, res_hi_d;
  logic [WIDTH-1:0] res_lo_q, res_lo_d;
  logic             dbz_q, dbz_d;

  logic [CW-1:0]    idx;
  logic [31:0]      rem_sh;
  logic [31:0]      alu_a, alu_b;
  logic [1:0]       alu_ctrl;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= IDLE;
      op_q     <= 1'b0;
      opa_q    <= '0;
      opb_q    <= '0;
      acc_q    <= '0;
      count_q  <= '0;
      quot_q   <= '0;
      res_hi_q <= '0;
      res_lo_q <= '0;
      dbz_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      op_q     <= op_d;
      opa_q    <= opa_d;
      opb_q    <= opb_d;
      acc_q    <= acc_d;
      count_q  <= count_d;
      quot_q   <= quot_d;
      res_hi_q <= res_hi_d;
      res_lo_q <= res_lo_d;
      dbz_q    <= dbz_d;
    end
  end

  // acc doubles as the partial product (multiply) and the partial remainder (divide)
  always_comb begin
    state_d  = state_q;
    op_d     = op_q;
    opa_d    = opa_q;
    opb_d    = opb_q;
    acc_d    = acc_q;
    count_d  = count_q;
    quot_d   = quot_q;
    res_hi_d = res_hi_q;
    res_lo_d = res_lo_q;
    dbz_d    = dbz_q;
    alu_a    = '0;
    alu_b    = '0;
    alu_ctrl = ALU_ADD;
    idx      = CW'(WIDTH - 1) - count_q;
    rem_sh   = {acc_q[30:0], opa_q[idx]};

    case (state_q)
      RUN: begin
        count_d = count_q + CW'(1);
        if (!op_q) begin
          alu_a = acc_q;
          alu_b = 32'(opa_q) << count_q;
          if (opb_q[count_q]) acc_d = bus.alu_out;
        end else begin
          alu_ctrl = ALU_SUB;
          alu_a    = rem_sh;
          alu_b    = 32'(opb_q);
          if (!bus.alu_out[31]) begin
            acc_d       = bus.alu_out;
            quot_d[idx] = 1'b1;
          end else begin
            acc_d       = rem_sh;
            quot_d[idx] = 1'b0;
          end
        end
        if (count_q == CW'(WIDTH - 1)) begin
          state_d = DONE;
          if (!op_q) begin
            res_hi_d = acc_d[2*WIDTH-1:WIDTH];
            res_lo_d = acc_d[WIDTH-1:0];
          end else begin
            res_hi_d = acc_d[WIDTH-1:0];
            res_lo_d = quot_d;
          end
        end
      end
      default: begin
        if (state_q == DONE) state_d = IDLE;
        if (bus.start) begin
          op_d    = bus.op;
          opa_d   = bus.opa;
          opb_d   = bus.opb;
          acc_d   = '0;
          count_d = '0;
          quot_d  = '0;
          dbz_d   = 1'b0;
          if (bus.op && (bus.opb == '0)) begin
            state_d  = DONE;
            res_lo_d = '1;
            res_hi_d = bus.opa;
            dbz_d    = 1'b1;
          end else begin
            state_d = RUN;
          end
        end
      end
    endcase
  end

  assign bus.busy        = (state_q == RUN);
  assign bus.done        = (state_q == DONE);
  assign bus.result_hi   = res_hi_q;
  assign bus.result_lo   = res_lo_q;
  assign bus.div_by_zero = dbz_q;
  assign bus.alu_a       = alu_a;
  assign bus.alu_b       = alu_b;
  assign bus.alu_ctrl    = alu_ctrl;
endmodule

// File: tb/tb_muldiv_seq.sv
// Self-checking bench for muldiv_seq: directed cases plus random operations compared
// against plain arithmetic (a*b, a/b, a%b) with a behavioural ALU attached.
module tb_muldiv_seq;
  localparam int W = 16;

  logic clk = 1'b0;
  logic rst;
  int   total = 0;
  int   bad   = 0;

  always #5 clk = ~clk;

  muldiv_seq_if #(.WIDTH(W)) bus ();

  muldiv_seq #(.WIDTH(W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  always_comb begin
    case (bus.alu_ctrl)
      2'b00:   bus.alu_out = bus.alu_a + bus.alu_b;
      2'b01:   bus.alu_out = bus.alu_a - bus.alu_b;
      2'b10:   bus.alu_out = bus.alu_a | bus.alu_b;
      default: bus.alu_out = bus.alu_a & bus.alu_b;
    endcase
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic launch(input bit o, input logic [W-1:0] a, input logic [W-1:0] b);
    bus.start = 1'b1;
    bus.op    = o;
    bus.opa   = a;
    bus.opb   = b;
    @(negedge clk);
    bus.start = 1'b0;
  endtask

  task automatic wait_done(input bit o, input bit dbz, input int inject);
    int cyc;
    cyc = 1;
    while (!bus.done && cyc < 40) begin
      check("busy_running", 64'(bus.busy), 64'(1));
      check("alu_ctrl_run", 64'(bus.alu_ctrl), o ? 64'(1) : 64'(0));
      if (cyc == inject) begin
        bus.start = 1'b1;
        bus.op    = 1'b0;
        bus.opa   = 16'($urandom);
        bus.opb   = 16'($urandom);
      end
      @(negedge clk);
      bus.start = 1'b0;
      cyc++;
    end
    check("latency", 64'(cyc), dbz ? 64'(1) : 64'(W + 1));
    check("busy_with_done", 64'(bus.busy), 64'(0));
  endtask

  task automatic expect_result(input bit o, input logic [W-1:0] a, input logic [W-1:0] b);
    logic [31:0]  p;
    logic [W-1:0] eh, el;
    logic         ed;
    if (!o) begin
      p  = 32'(a) * 32'(b);
      eh = p[31:16];
      el = p[15:0];
      ed = 1'b0;
    end else if (b == '0) begin
      eh = a;
      el = '1;
      ed = 1'b1;
    end else begin
      eh = a % b;
      el = a / b;
      ed = 1'b0;
    end
    check("result_hi", 64'(bus.result_hi), 64'(eh));
    check("result_lo", 64'(bus.result_lo), 64'(el));
    check("div_by_zero", 64'(bus.div_by_zero), 64'(ed));
  endtask

  task automatic run(input bit o, input logic [W-1:0] a, input logic [W-1:0] b, input int inject);
    launch(o, a, b);
    wait_done(o, o && (b == '0), inject);
    expect_result(o, a, b);
    @(negedge clk);
    check("done_pulse_len", 64'(bus.done), 64'(0));
    check("idle_busy", 64'(bus.busy), 64'(0));
    check("idle_alu_a", 64'(bus.alu_a), 64'(0));
    expect_result(o, a, b);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    bit           o;
    logic [W-1:0] a, b;

    bus.start = 1'b0;
    bus.op    = 1'b0;
    bus.opa   = '0;
    bus.opb   = '0;
    rst       = 1'b1;
    #12;
    check("rst_busy", 64'(bus.busy), 64'(0));
    check("rst_done", 64'(bus.done), 64'(0));
    check("rst_hi", 64'(bus.result_hi), 64'(0));
    check("rst_lo", 64'(bus.result_lo), 64'(0));
    check("rst_dbz", 64'(bus.div_by_zero), 64'(0));
    check("rst_alu_a", 64'(bus.alu_a), 64'(0));
    check("rst_alu_b", 64'(bus.alu_b), 64'(0));
    check("rst_alu_ctrl", 64'(bus.alu_ctrl), 64'(0));
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);

    run(1'b0, 16'd3, 16'd5, 0);
    run(1'b0, 16'hFFFF, 16'hFFFF, 0);
    run(1'b1, 16'd100, 16'd7, 0);
    run(1'b1, 16'd5, 16'd9, 0);
    run(1'b1, 16'h1234, 16'd0, 0);
    run(1'b0, 16'd3, 16'd5, 5);

    // back-to-back: second start presented during the done cycle
    launch(1'b0, 16'd3, 16'd5);
    wait_done(1'b0, 1'b0, 0);
    expect_result(1'b0, 16'd3, 16'd5);
    launch(1'b1, 16'd6, 16'd4);
    wait_done(1'b1, 1'b0, 0);
    expect_result(1'b1, 16'd6, 16'd4);
    @(negedge clk);

    // asynchronous reset in the middle of a multiply
    launch(1'b0, 16'd3, 16'd5);
    repeat (7) @(negedge clk);
    #2 rst = 1'b1;
    #1;
    check("midrst_busy", 64'(bus.busy), 64'(0));
    check("midrst_done", 64'(bus.done), 64'(0));
    check("midrst_hi", 64'(bus.result_hi), 64'(0));
    check("midrst_lo", 64'(bus.result_lo), 64'(0));
    check("midrst_dbz", 64'(bus.div_by_zero), 64'(0));
    check("midrst_alu_a", 64'(bus.alu_a), 64'(0));
    check("midrst_alu_b", 64'(bus.alu_b), 64'(0));
    check("midrst_alu_ctrl", 64'(bus.alu_ctrl), 64'(0));
    @(negedge clk);
    rst = 1'b0;
    repeat (3) begin
      @(negedge clk);
      check("postrst_busy", 64'(bus.busy), 64'(0));
      check("postrst_done", 64'(bus.done), 64'(0));
    end
    run(1'b0, 16'd7, 16'd7, 0);

    for (int i = 0; i < 24; i++) begin
      o = 1'($urandom);
      a = 16'($urandom);
      b = (($urandom % 5) == 0) ? 16'd0 : 16'($urandom);
      run(o, a, b, 0);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
